// File: rtl/vecaris_pkg.sv
// ----------------------------------------------------------------------------
// vecaris_pkg
// Shared definitions for the 16-bit ALU datapath and its result stage.
//   - ALU op-code constants (3-bit op field)
//   - default datapath / register-address widths
//   - writeback buffer state encoding
//   - op_updates_carry(): which ops are allowed to write the C flag
// ----------------------------------------------------------------------------
package vecaris_pkg;

    localparam int DEFAULT_DATA_W     = 16;
    localparam int DEFAULT_REG_ADDR_W = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_SL  = 3'b011;
    localparam logic [2:0] OP_SR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_ZLE = 3'b111;

    // Occupancy of the writeback skid buffer.
    //   EMPTY : nothing buffered
    //   ONE   : output entry only
    //   TWO   : output entry plus skid entry
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    // Only arithmetic and left-shift produce a meaningful carry-out; every
    // other op leaves the architectural C flag untouched.
    function automatic logic op_updates_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SL);
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// ----------------------------------------------------------------------------
// wb_skid_buffer
// Two-entry FIFO-ordered skid buffer carrying {register address, data} from
// the ALU result stage to the register-file write port.
//
// Handshake: a transfer happens on a side exactly in the cycle where both
// valid and ready are high at the rising clock edge. The producer may not
// rely on ready before presenting valid; ready here is a registered signal
// that depends only on buffer occupancy, never on i_push_valid.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   i_push_valid      producer has an entry (already qualified by wb_en)
//   o_push_ready      registered; high unless both entries are occupied
//   i_push_addr/data  entry payload
//   i_out_ready       consumer (register file) accepts the output entry
//   o_out_addr/data   oldest entry; stable while held
//   o_fwd_addr/data   youngest buffered entry (zero when empty)
//   o_state           current occupancy (EMPTY / ONE / TWO)
// ----------------------------------------------------------------------------
module wb_skid_buffer
    import vecaris_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push_valid,
    output logic              o_push_ready,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_fwd_addr,
    output logic [DATA_W-1:0] o_fwd_data,
    output buf_state_e        o_state
);

    buf_state_e        r_state;
    buf_state_e        w_state_nxt;
    logic              r_push_ready;

    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_skid_addr;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_push;
    logic              w_drain;
    logic              w_load_out_from_in;
    logic              w_load_out_from_skid;
    logic              w_load_skid;

    assign w_push  = i_push_valid && r_push_ready;
    assign w_drain = (r_state != EMPTY) && i_out_ready;

    // Next-state and datapath load enables. In TWO the ready flop is already
    // low, so a push cannot coincide with that state.
    always_comb begin
        w_state_nxt          = r_state;
        w_load_out_from_in   = 1'b0;
        w_load_out_from_skid = 1'b0;
        w_load_skid          = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_state_nxt        = ONE;
                    w_load_out_from_in = 1'b1;
                end
            end
            ONE: begin
                case ({w_push, w_drain})
                    2'b01: w_state_nxt = EMPTY;
                    2'b10: begin
                        w_state_nxt = TWO;
                        w_load_skid = 1'b1;
                    end
                    // Drain and push together: the new entry replaces the
                    // leaving one directly, so there is no bubble.
                    2'b11: w_load_out_from_in = 1'b1;
                    default: ;
                endcase
            end
            TWO: begin
                if (w_drain) begin
                    w_state_nxt          = ONE;
                    w_load_out_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_push_ready <= 1'b1;
            r_out_addr   <= '0;
            r_out_data   <= '0;
            r_skid_addr  <= '0;
            r_skid_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            // Registered ready: low exactly while the buffer holds two entries.
            r_push_ready <= (w_state_nxt != TWO);
            if (w_load_out_from_in) begin
                r_out_addr <= i_push_addr;
                r_out_data <= i_push_data;
            end else if (w_load_out_from_skid) begin
                r_out_addr <= r_skid_addr;
                r_out_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_addr <= i_push_addr;
                r_skid_data <= i_push_data;
            end
        end
    end

    // Youngest buffered entry; zero when nothing is buffered so the
    // forwarding bus never carries a stale value.
    always_comb begin
        o_fwd_addr = '0;
        o_fwd_data = '0;
        case (r_state)
            ONE: begin
                o_fwd_addr = r_out_addr;
                o_fwd_data = r_out_data;
            end
            TWO: begin
                o_fwd_addr = r_skid_addr;
                o_fwd_data = r_skid_data;
            end
            default: ;
        endcase
    end

    assign o_push_ready = r_push_ready;
    assign o_out_addr   = r_out_addr;
    assign o_out_data   = r_out_data;
    assign o_state      = r_state;

endmodule

// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
// Execute-to-writeback stage behind the 16-bit ALU. Captures each ALU result
// with its destination register, keeps the architectural Z and C flags and
// feeds the register-file write port through a 2-entry skid buffer. The
// youngest pending writeback is exposed for operand forwarding.
//
// Handshake: input side transfers when in_valid && in_ready at a rising
// edge; output side transfers when wb_valid && wb_ready at a rising edge.
// in_ready is registered and does not depend on in_valid.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        ALU result handshake
//   in_s, in_cout, in_zero     ALU result, carry-out, zero
//   in_op                      op code that produced the result
//   in_rd                      destination register
//   in_wb_en                   result goes to the register file
//   in_flag_en                 result updates flags
//   wb_valid/ready/addr/data   register-file write port
//   flag_z, flag_c             architectural flags
//   fwd_valid/addr/data        youngest pending writeback
// ----------------------------------------------------------------------------
module alu_result_stage
    import vecaris_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_s,
    input  logic                  in_cout,
    input  logic                  in_zero,
    input  logic [2:0]            in_op,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wb_en,
    input  logic                  in_flag_en,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]     fwd_data
);

    logic       w_in_ready;
    logic       w_accept;
    logic       w_push;
    buf_state_e w_buf_state;

    logic       r_flag_z;
    logic       r_flag_c;

    // Flag-only results (in_wb_en=0) are still accepted but never buffered.
    assign w_accept = in_valid && w_in_ready;
    assign w_push   = w_accept && in_wb_en;

    wb_skid_buffer #(
        .ADDR_W (REG_ADDR_W),
        .DATA_W (DATA_W)
    ) u_wb_skid_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (w_push),
        .o_push_ready (w_in_ready),
        .i_push_addr  (in_rd),
        .i_push_data  (in_s),
        .i_out_ready  (wb_ready),
        .o_out_addr   (wb_addr),
        .o_out_data   (wb_data),
        .o_fwd_addr   (fwd_addr),
        .o_fwd_data   (fwd_data),
        .o_state      (w_buf_state)
    );

    // Flags follow every accepted flag-updating result, independent of
    // whether it is written back or how full the buffer is.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (w_accept && in_flag_en) begin
            r_flag_z <= in_zero;
            if (op_updates_carry(in_op)) begin
                r_flag_c <= in_cout;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign wb_valid  = (w_buf_state != EMPTY);
    assign fwd_valid = (w_buf_state != EMPTY);
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-to-writeback stage directly downstream of the 16-bit ALU. Captures each ALU result together with its destination register and flag-update intent, maintains the architectural Z and C flags, and presents results to the register-file write port through a 2-entry valid/ready skid buffer. Also exposes the youngest pending writeback for operand forwarding.

## Interface
- DATA_W, 16, datapath width; must match ALU `s` width.
- REG_ADDR_W, 3, register-file address width (8 registers).

- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  ALU result and sideband valid this cycle.
- in_ready  output  1  stage can accept; registered, equals "skid entry empty".
- in_s  input  DATA_W  ALU result `s`.
- in_cout  input  1  ALU carry-out.
- in_zero  input  1  ALU zero.
- in_op  input  3  ALU op code that produced the result.
- in_rd  input  REG_ADDR_W  destination register.
- in_wb_en  input  1  result is written to the register file.
- in_flag_en  input  1  result updates flags.
- wb_valid  output  1  writeback entry present.
- wb_ready  input  1  register file accepts the entry.
- wb_addr  output  REG_ADDR_W  writeback register address.
- wb_data  output  DATA_W  writeback data.
- flag_z  output  1  architectural zero flag.
- flag_c  output  1  architectural carry flag.
- fwd_valid  output  1  forwarding entry valid.
- fwd_addr  output  REG_ADDR_W  forwarded register address.
- fwd_data  output  DATA_W  forwarded data.

## Operation
- Accept = in_valid && in_ready. Nothing is captured without accept.
- Buffer FSM, states: EMPTY (no entries), ONE (output entry only), TWO (output + skid entry).
  - EMPTY: accept with in_wb_en=1 -> ONE.
  - ONE: drain (wb_valid && wb_ready) without push -> EMPTY; push without drain -> TWO; push with drain -> ONE (new entry becomes the output entry).
  - TWO: drain -> ONE (skid moves to output); push is impossible because in_ready=0.
  - A push is an accept with in_wb_en=1. An accept with in_wb_en=0 is flag-only and never enters the buffer.
- Ordering is strict FIFO; wb_* always shows the oldest entry.
- Flags update on accept when in_flag_en=1, regardless of in_wb_en and buffer state:
  - Z <= in_zero for every op.
  - C <= in_cout for ADD (000), SUB (001), SL (011). For all other ops C is held.
  - in_flag_en=0: both flags held.
- Forwarding: fwd_* reflects the youngest buffered entry (skid in TWO, output in ONE). fwd_valid=0 in EMPTY. Forwarding never includes the entry being accepted this cycle.
- Reset (rst_n=0 at a rising edge): state EMPTY, all entries discarded, including mid-drain. Outputs: wb_valid=0, wb_addr=0, wb_data=0, fwd_valid=0, fwd_addr=0, fwd_data=0, flag_z=0, flag_c=0, in_ready=1 from the first cycle after reset.

## Timing
- Accept in cycle N -> wb_valid=1 with that entry in N+1 (EMPTY case). Flags are visible in N+1.
- in_ready is registered. It deasserts in the cycle after entry to TWO and reasserts in the cycle after the drain out of TWO.
- wb_addr/wb_data are stable while wb_valid=1 && wb_ready=0.
- Simultaneous accept and drain in ONE: the drained entry leaves, the new entry is on wb_* next cycle, and there is no bubble.
- Sustained throughput is 1 entry/cycle while wb_ready=1.

## Structure
- Shared package `vecaris_pkg`: ALU op constants OP_ADD=3'b000, OP_SUB=3'b001, OP_NOT=3'b010, OP_SL=3'b011, OP_SR=3'b100, OP_AND=3'b101, OP_OR=3'b110, OP_ZLE=3'b111; DATA_W and REG_ADDR_W defaults; buffer state enum {EMPTY, ONE, TWO}.
- One sub-module: `wb_skid_buffer` (2-entry skid buffer, payload = addr+data, valid/ready both sides). The flag logic stays in the top module.

## Test plan
- Reset then a single accept (op=ADD, s=16'h1234, cout=1, zero=0, rd=3, wb_en=1, flag_en=1) -> next cycle wb_valid=1, wb_addr=3, wb_data=16'h1234, flag_c=1, flag_z=0.
- Hold wb_ready=0 and push three entries back-to-back (rd=1,2,3) -> in_ready=0 after the second push, third not accepted. Raise wb_ready -> drains 1 then 2 in order; third accepted once in_ready=1.
- Flag-only ZLE (op=111, zero=1, wb_en=0, flag_en=1, cout=1) -> flag_z=1, flag_c unchanged, wb_valid stays 0.
- Op AND with cout=1, flag_en=1 after C=0 -> flag_c stays 0. Op SL with cout=1 -> flag_c=1.
- wb_ready=1 continuously with 8 consecutive accepts -> 8 writebacks on consecutive cycles, no bubbles. fwd_data equals the most recently accepted data one cycle after each accept.
- Assert rst_n=0 while in TWO with flags set -> next cycle wb_valid=0, fwd_valid=0, flag_z=0, flag_c=0, in_ready=1, and no stale entry after reset release.
